// File: rtl/demux1x4_lanes_pkg.sv
// Shared PHY lane constants for the 1-to-4 receive lane demultiplexer.
// Holds the lane count, pointer width and valid_out encodings.
package demux1x4_lanes_pkg;

    localparam int unsigned LANES      = 4;
    localparam int unsigned LANE_IDX_W = 2;
    localparam int unsigned DEF_WIDTH  = 8;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;
    typedef logic [LANES-1:0]      lane_mask_t;

    localparam lane_mask_t VALID_FULL = '1;
    localparam lane_mask_t VALID_NONE = '0;

    // Lanes 0..p-1 valid, i.e. (1<<p)-1.
    function automatic lane_mask_t partial_mask(input lane_idx_t p);
        lane_mask_t m;
        m = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i < 32'(p)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/demux1x4_lanes_idle_ctr.sv
// Saturating idle-cycle counter; o_hit flags the edge on which an enabled
// increment reaches IDLE_LIMIT. IDLE_LIMIT=0 keeps the flag permanently low.
module demux_idle_ctr #(
    parameter int unsigned IDLE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_hit
);

    localparam int unsigned CW = (IDLE_LIMIT > 0) ? $clog2(IDLE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT    = CW'(IDLE_LIMIT);
    localparam logic [CW-1:0] LIMIT_M1 = (IDLE_LIMIT > 0) ? CW'(IDLE_LIMIT - 1) : '0;
    localparam bit            ENABLED  = (IDLE_LIMIT > 0);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Looks one step ahead so the flush lands on the edge the limit is reached.
    always_comb begin
        o_hit = 1'b0;
        if (ENABLED && i_en && (r_count == LIMIT_M1)) begin
            o_hit = 1'b1;
        end
    end

endmodule

// File: rtl/demux1x4_lanes.sv
// Receive-side 1-to-4 lane demultiplexer: valid bytes fill lanes round-robin,
// full words strobe out, partial words flush after an idle gap.
module demux1x4_lanes
    import demux1x4_lanes_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned IDLE_LIMIT = 4
) (
    input  logic             clk4f,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             valid_in,
    input  logic             align,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       valid_out,
    output logic             word_strobe,
    output logic [1:0]       lane_ptr
);

    localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

    logic [WIDTH-1:0] r_stage [LANES];
    logic [WIDTH-1:0] r_out   [LANES];
    lane_mask_t       r_valid;
    logic             r_strobe;
    lane_idx_t        r_ptr;

    logic       w_idle_en;
    logic       w_idle_clr;
    logic       w_idle_hit;
    logic       w_flush;
    lane_mask_t w_flush_mask;

    assign w_idle_en    = !valid_in && (r_ptr != '0);
    assign w_idle_clr   = valid_in || align || (r_ptr == '0) || w_idle_hit;
    assign w_flush      = w_idle_hit && !align;
    assign w_flush_mask = partial_mask(r_ptr);

    demux_idle_ctr #(
        .IDLE_LIMIT(IDLE_LIMIT)
    ) u_idle_ctr (
        .i_clk   (clk4f),
        .i_reset (reset),
        .i_clear (w_idle_clr),
        .i_en    (w_idle_en),
        .o_hit   (w_idle_hit)
    );

    always_ff @(posedge clk4f) begin
        if (reset) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                r_stage[i] <= '0;
                r_out[i]   <= '0;
            end
            r_valid  <= VALID_NONE;
            r_strobe <= 1'b0;
            r_ptr    <= '0;
        end else begin
            r_strobe <= 1'b0;
            if (align) begin
                // Realign discards the partial word; a byte on the same edge starts lane 0.
                for (int unsigned i = 0; i < LANES; i++) begin
                    r_stage[i] <= '0;
                end
                if (valid_in) begin
                    r_stage[0] <= in;
                    r_ptr      <= lane_idx_t'(1);
                end else begin
                    r_ptr <= '0;
                end
            end else if (valid_in) begin
                if (r_ptr == LAST_LANE) begin
                    for (int unsigned i = 0; i < LANES - 1; i++) begin
                        r_out[i] <= r_stage[i];
                    end
                    r_out[LANES-1] <= in;
                    r_valid        <= VALID_FULL;
                    r_strobe       <= 1'b1;
                    r_ptr          <= '0;
                end else begin
                    r_stage[r_ptr] <= in;
                    r_ptr          <= r_ptr + lane_idx_t'(1);
                end
            end else if (w_flush) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    r_out[i] <= w_flush_mask[i] ? r_stage[i] : '0;
                end
                r_valid  <= w_flush_mask;
                r_strobe <= 1'b1;
                r_ptr    <= '0;
            end
        end
    end

    assign out0        = r_out[0];
    assign out1        = r_out[1];
    assign out2        = r_out[2];
    assign out3        = r_out[3];
    assign valid_out   = r_valid;
    assign word_strobe = r_strobe;
    assign lane_ptr    = r_ptr;

endmodule

// File: tb/tb_demux1x4_lanes.sv
// Scoreboard bench for demux1x4_lanes: expected words are queued as stimulus
// is driven and popped whenever the DUT raises word_strobe.
module tb_demux1x4_lanes;

    logic       clk4f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in = 8'h00;
    logic       valid_in = 1'b0;
    logic       align = 1'b0;
    logic [7:0] out0, out1, out2, out3;
    logic [3:0] valid_out;
    logic       word_strobe;
    logic [1:0] lane_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    // {valid_out, out3, out2, out1, out0}
    logic [35:0] exp_q [$];
    logic [35:0] mon_exp;
    logic [35:0] mon_got;

    demux1x4_lanes #(
        .WIDTH      (8),
        .IDLE_LIMIT (4)
    ) dut (
        .clk4f       (clk4f),
        .reset       (reset),
        .in          (in),
        .valid_in    (valid_in),
        .align       (align),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .valid_out   (valid_out),
        .word_strobe (word_strobe),
        .lane_ptr    (lane_ptr)
    );

    always #5 clk4f = ~clk4f;

    always @(negedge clk4f) begin
        if (word_strobe === 1'b1) begin
            mon_got = {valid_out, out3, out2, out1, out0};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got word %h, required no strobe", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got[31:0] !== mon_exp[31:0]) begin
                    n_fail++;
                    $display("FAIL word_data: got %h, required %h", mon_got[31:0], mon_exp[31:0]);
                end
                n_checks++;
                if (mon_got[35:32] !== mon_exp[35:32]) begin
                    n_fail++;
                    $display("FAIL word_valid: got %b, required %b", mon_got[35:32], mon_exp[35:32]);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic a);
        valid_in = v;
        in       = d;
        align    = a;
        @(posedge clk4f);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(1'b1, 8'h5A, 1'b0);
        cyc(1'b1, 8'hA5, 1'b0);
        reset = 1'b0;
        n_checks++;
        if ({out3, out2, out1, out0} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0", {out3, out2, out1, out0});
        end
        n_checks++;
        if (valid_out !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valid: got %b, required 0000", valid_out);
        end
        n_checks++;
        if (word_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobe: got %b, required 0", word_strobe);
        end
        n_checks++;
        if (lane_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ptr: got %0d, required 0", lane_ptr);
        end
        idle(2);
    endtask

    task automatic test_full_word();
        cyc(1'b1, 8'hA0, 1'b0);
        cyc(1'b1, 8'hA1, 1'b0);
        n_checks++;
        if (lane_ptr !== 2'd2) begin
            n_fail++;
            $display("FAIL full_ptr_mid: got %0d, required 2", lane_ptr);
        end
        cyc(1'b1, 8'hA2, 1'b0);
        exp_q.push_back({4'b1111, 8'hA3, 8'hA2, 8'hA1, 8'hA0});
        cyc(1'b1, 8'hA3, 1'b0);
        n_checks++;
        if (word_strobe !== 1'b1 || lane_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL full_latency: got strobe %b ptr %0d, required strobe 1 ptr 0", word_strobe, lane_ptr);
        end
        idle(1);
        n_checks++;
        if (word_strobe !== 1'b0 || valid_out !== 4'b1111) begin
            n_fail++;
            $display("FAIL full_hold: got strobe %b valid %b, required strobe 0 valid 1111", word_strobe, valid_out);
        end
        idle(1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_gaps();
        cyc(1'b1, 8'h11, 1'b0);
        idle(1);
        cyc(1'b1, 8'h22, 1'b0);
        idle(1);
        cyc(1'b1, 8'h33, 1'b0);
        n_checks++;
        if (lane_ptr !== 2'd3) begin
            n_fail++;
            $display("FAIL gaps_ptr: got %0d, required 3", lane_ptr);
        end
        exp_q.push_back({4'b1111, 8'h44, 8'h33, 8'h22, 8'h11});
        cyc(1'b1, 8'h44, 1'b0);
        idle(6);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL gaps_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_idle_restart();
        cyc(1'b1, 8'h12, 1'b0);
        idle(3);
        cyc(1'b1, 8'h34, 1'b0);
        idle(3);
        cyc(1'b1, 8'h56, 1'b0);
        idle(3);
        n_checks++;
        if (lane_ptr !== 2'd3 || word_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_ptr: got ptr %0d strobe %b, required ptr 3 strobe 0", lane_ptr, word_strobe);
        end
        exp_q.push_back({4'b1111, 8'h78, 8'h56, 8'h34, 8'h12});
        cyc(1'b1, 8'h78, 1'b0);
        idle(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL restart_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_partial_flush();
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h66, 1'b0);
        exp_q.push_back({4'b0011, 8'h00, 8'h00, 8'h66, 8'h55});
        idle(3);
        n_checks++;
        if (word_strobe !== 1'b0 || lane_ptr !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_early: got strobe %b ptr %0d, required strobe 0 ptr 2", word_strobe, lane_ptr);
        end
        idle(1);
        n_checks++;
        if (word_strobe !== 1'b1 || lane_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_edge: got strobe %b ptr %0d, required strobe 1 ptr 0", word_strobe, lane_ptr);
        end
        idle(6);
        n_checks++;
        if (exp_q.size() != 0 || valid_out !== 4'b0011) begin
            n_fail++;
            $display("FAIL flush2_drain: got %0d pending valid %b, required 0 pending valid 0011", exp_q.size(), valid_out);
        end
        cyc(1'b1, 8'hC1, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0);
        exp_q.push_back({4'b0111, 8'h00, 8'hC3, 8'hC2, 8'hC1});
        idle(6);
        cyc(1'b1, 8'hD1, 1'b0);
        exp_q.push_back({4'b0001, 8'h00, 8'h00, 8'h00, 8'hD1});
        idle(6);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL flush31_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_align();
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        cyc(1'b1, 8'h03, 1'b0);
        cyc(1'b1, 8'h77, 1'b1);
        n_checks++;
        if (lane_ptr !== 2'd1 || word_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL align_valid_ptr: got ptr %0d strobe %b, required ptr 1 strobe 0", lane_ptr, word_strobe);
        end
        cyc(1'b1, 8'h88, 1'b0);
        cyc(1'b1, 8'h99, 1'b0);
        exp_q.push_back({4'b1111, 8'hAA, 8'h99, 8'h88, 8'h77});
        cyc(1'b1, 8'hAA, 1'b0);
        idle(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL align_drain: got %0d pending, required 0", exp_q.size());
        end
        cyc(1'b1, 8'hE1, 1'b0);
        cyc(1'b1, 8'hE2, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (lane_ptr !== 2'd0 || word_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL align_idle_ptr: got ptr %0d strobe %b, required ptr 0 strobe 0", lane_ptr, word_strobe);
        end
        n_checks++;
        if (valid_out !== 4'b1111 || out0 !== 8'h77 || out3 !== 8'hAA) begin
            n_fail++;
            $display("FAIL align_hold: got valid %b out0 %h out3 %h, required 1111 77 AA", valid_out, out0, out3);
        end
        idle(5);
        cyc(1'b1, 8'hF1, 1'b0);
        cyc(1'b1, 8'hF2, 1'b0);
        idle(3);
        cyc(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (lane_ptr !== 2'd0 || word_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL align_over_flush: got ptr %0d strobe %b, required ptr 0 strobe 0", lane_ptr, word_strobe);
        end
        idle(3);
    endtask

    task automatic test_reset_midword();
        cyc(1'b1, 8'h31, 1'b0);
        cyc(1'b1, 8'h32, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        n_checks++;
        if (lane_ptr !== 2'd0 || valid_out !== 4'b0000 || word_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got ptr %0d valid %b strobe %b, required 0 0000 0", lane_ptr, valid_out, word_strobe);
        end
        cyc(1'b1, 8'hB0, 1'b0);
        cyc(1'b1, 8'hB1, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0);
        exp_q.push_back({4'b1111, 8'hB3, 8'hB2, 8'hB1, 8'hB0});
        cyc(1'b1, 8'hB3, 1'b0);
        idle(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                b[k] = 8'($urandom_range(0, 255));
            end
            for (int k = 0; k < 4; k++) begin
                if (k == 3) begin
                    exp_q.push_back({4'b1111, b[3], b[2], b[1], b[0]});
                end
                cyc(1'b1, b[k], 1'b0);
                n_checks++;
                if (word_strobe !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL b2b_strobe: word %0d byte %0d got %b, required %b", w, k, word_strobe, (k == 3));
                end
            end
        end
        idle(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_gaps();
        test_idle_restart();
        test_partial_flush();
        test_align();
        test_reset_midword();
        test_back_to_back();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
